// File: rtl/exe_pipe_stage.sv
// Registered execute stage: operand select, ALU, N/Z/C/V flags, valid/ready handshake.
// Build option EXE_MUL_EN enables an iterative shift-add multiplier for alu_oc=7.
module exe_pipe_stage #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] value1,
   input  logic [WIDTH-1:0] value2,
   input  logic [WIDTH-1:0] immediate,
   input  logic             ir_op,
   input  logic [2:0]       alu_oc,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [3:0]       cpsr_flags
);

   localparam logic [SHW-1:0] AMT_ONE = SHW'(1);

   logic [WIDTH-1:0] op2, alu_res, shl_tmp, shr_tmp;
   logic [WIDTH:0]   add_full;
   logic [SHW-1:0]   amt;
   logic             alu_c, alu_v, xfer, is_mul;
   logic             load_en, load_c, load_v, load_sf;
   logic [WIDTH-1:0] result_d, result_q;
   logic [3:0]       flags_d, flags_q, cpsr_q;
   logic             out_valid_q;

   always_comb begin
      op2      = ir_op ? value2 : immediate;
      amt      = op2[SHW-1:0];
      add_full = {1'b0, value1} + {1'b0, op2};
      // Shifted by amt-1 so the last bit shifted out sits at the edge.
      shl_tmp  = value1 << (amt - AMT_ONE);
      shr_tmp  = value1 >> (amt - AMT_ONE);
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (alu_oc)
         3'd0: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (value1[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != value1[WIDTH-1]);
         end
         3'd1: begin
            alu_res = value1 - op2;
            alu_c   = (value1 >= op2);
            alu_v   = (value1[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != value1[WIDTH-1]);
         end
         3'd2: alu_res = value1 & op2;
         3'd3: alu_res = value1 | op2;
         3'd4: alu_res = value1 ^ op2;
         3'd5: begin
            alu_res = value1 << amt;
            alu_c   = (amt != '0) && shl_tmp[WIDTH-1];
         end
         3'd6: begin
            alu_res = value1 >> amt;
            alu_c   = (amt != '0) && shr_tmp[0];
         end
         default: alu_res = '0;
      endcase
   end

`ifdef EXE_MUL_EN
   localparam logic [0:0]     IDLE     = 1'b0;
   localparam logic [0:0]     MUL      = 1'b1;
   localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};

   logic [0:0]       state_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, mul_sum;
   logic             sf_q;

   assign is_mul   = (alu_oc == 3'd7);
   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign mul_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sf_q     <= 1'b0;
      end else if (state_q == IDLE) begin
         if (xfer && is_mul) begin
            state_q  <= MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= value1;
            mplier_q <= op2;
            sf_q     <= set_flags;
         end
      end else begin
         acc_q    <= mul_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + AMT_ONE;
         if (cnt_q == CNT_LAST) state_q <= IDLE;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign in_ready = !out_valid_q || out_ready;
`endif

   assign xfer = in_valid && in_ready;

   always_comb begin
      load_en  = xfer && !is_mul;
      result_d = alu_res;
      load_c   = alu_c;
      load_v   = alu_v;
      load_sf  = set_flags;
`ifdef EXE_MUL_EN
      // Final iteration folds the last partial product straight into the result.
      if (state_q == MUL && cnt_q == CNT_LAST) begin
         load_en  = 1'b1;
         result_d = mul_sum;
         load_c   = 1'b0;
         load_v   = 1'b0;
         load_sf  = sf_q;
      end
`endif
      flags_d = {result_d[WIDTH-1], (result_d == '0), load_c, load_v};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         cpsr_q      <= '0;
      end else if (load_en) begin
         out_valid_q <= 1'b1;
         result_q    <= result_d;
         flags_q     <= flags_d;
         if (load_sf) cpsr_q <= flags_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign flags      = flags_q;
   assign cpsr_flags = cpsr_q;

endmodule

// File: doc/exe_pipe_stage.md
Name: exe_pipe_stage

Overview:
Parametrised, registered execute stage for the SCC core, generalising the combinational execute path. Selects register or immediate second operand, performs the ALU operation, and produces a result plus fully defined N/Z/C/V flags. A valid/ready handshake on input and output allows back-pressure from memory/writeback. An optional iterative multiplier stalls the stage for multi-cycle MUL.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of two)
SHW, $clog2(WIDTH), shift-amount width taken from op2[SHW-1:0]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operation presented
in_ready  out  1  stage accepts operation this cycle
value1  in  WIDTH  operand 1 (register)
value2  in  WIDTH  register operand 2
immediate  in  WIDTH  immediate operand 2
ir_op  in  1  1: op2=value2, 0: op2=immediate
alu_oc  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSL, 6 LSR, 7 MUL
set_flags  in  1  update cpsr_flags with this op's flags
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  registered result
flags  out  4  this result's {N,Z,C,V}
cpsr_flags  out  4  architectural {N,Z,C,V}, sticky until next set_flags op

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, flags=0, cpsr_flags=0; in-flight MUL discarded.
- in_ready = (state==IDLE) && (!out_valid || out_ready); transfer when in_valid&&in_ready; operands and set_flags captured at transfer.
- States: IDLE, MUL. IDLE: non-MUL transfer -> result/flags registered, out_valid=1 next cycle (latency 1). MUL transfer -> MUL, counter=0.
- MUL: shift-add one multiplier bit/cycle; after WIDTH cycles loads low WIDTH bits of product into result, out_valid=1, returns to IDLE (latency WIDTH+1). in_ready=0 throughout.
- Output hold: out_valid&&!out_ready -> result/flags stable; out_valid clears on handshake unless a new transfer occurs the same cycle (back-to-back at 1 op/cycle).
- Arithmetic mod 2^WIDTH. N=result[WIDTH-1]; Z=(result==0).
- C: ADD carry-out; SUB no-borrow (value1>=op2 unsigned); LSL last bit shifted out (op1[WIDTH-amt]); LSR op1[amt-1]; shift amt 0 -> result=op1, C=0; AND/OR/XOR/MUL C=0.
- V: ADD/SUB signed overflow; all others 0.
- cpsr_flags updated with flags on the same edge result is loaded, only if captured set_flags=1.
- Reset mid-MUL: aborted, no result, cpsr_flags=0.

Optional Feature:
EXE_MUL_EN: defined -> MUL iterative as above. Undefined -> no MUL state/datapath; alu_oc=7 executes in 1 cycle with result=0, flags {0,1,0,0}.

Test Plan:
- ADD 0x7FFFFFFF+1, ir_op=0, imm=1, set_flags=1 -> next cycle result=0x80000000, flags=cpsr=1001 (N,V).
- SUB 5-5 register, set_flags=1 -> result=0, flags 0110; following AND with set_flags=0 leaves cpsr=0110.
- LSL 0x80000001 by 1 -> result=0x00000002, C=1; LSR by 0 -> result=op1, C=0.
- Back-pressure: out_ready=0 three cycles after ADD 2+3 -> in_ready=0, result=5 held; out_ready=1 with new op accepted same cycle, no loss/duplication.
- MUL 0x10000 * 0x10001 (EXE_MUL_EN) -> out_valid exactly 33 cycles after transfer, result=0x00010000, Z=0, C=V=0; rst at cycle 10 -> out_valid=0, no result.
- EXE_MUL_EN undefined, alu_oc=7 -> 1-cycle latency, result=0, flags 0100.
